// File: rtl/aux_channel_classifier_if.sv
// Signal bundle between the aux sample producer and the channel classifier.
// The producer side uses the master modport; the classifier uses the slave modport.
interface aux_channel_classifier_if #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int WINDOW_LOG2  = 4
);
  localparam int ACC_W = SAMPLE_WIDTH + WINDOW_LOG2;

  logic                    enable;
  logic                    sample_valid;
  logic [SAMPLE_WIDTH-1:0] aux0;
  logic [SAMPLE_WIDTH-1:0] aux1;
  logic [SAMPLE_WIDTH-1:0] aux2;
  logic [SAMPLE_WIDTH-1:0] aux3;
  logic [ACC_W-1:0]        margin;
  logic [1:0]              network_output;
  logic                    result_valid;
  logic                    result_ambiguous;
  logic                    busy;
  logic [7:0]              dropped_count;

  modport master (
    output enable, sample_valid, aux0, aux1, aux2, aux3, margin,
    input  network_output, result_valid, result_ambiguous, busy, dropped_count
  );

  modport slave (
    input  enable, sample_valid, aux0, aux1, aux2, aux3, margin,
    output network_output, result_valid, result_ambiguous, busy, dropped_count
  );
endinterface

// File: rtl/aux_channel_classifier.sv
// Integrates four aux channels over a fixed sample window, picks the strongest
// channel with a sequential compare, and publishes it unless the lead is below margin.
module aux_channel_classifier #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int WINDOW_LOG2  = 4
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  aux_channel_classifier_if.slave  bus
);
  localparam int ACC_W = SAMPLE_WIDTH + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2-1:0] COUNT_LAST = '1;
  localparam logic [WINDOW_LOG2-1:0] COUNT_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [WINDOW_LOG2-1:0]  count_reg, count_next;
  logic [1:0]              k_reg, k_next;
  logic [ACC_W-1:0]        best_reg, best_next;
  logic [ACC_W-1:0]        second_reg, second_next;
  logic [1:0]              idx_reg, idx_next;
  logic [1:0]              net_reg, net_next;
  logic                    amb_reg, amb_next;
  logic                    valid_reg, valid_next;
  logic [7:0]              dropped_reg, dropped_next;
  logic                    acc_clear;
  logic                    acc_add;
  logic                    busy;

  logic [SAMPLE_WIDTH-1:0] aux_vals [4];
  logic [ACC_W-1:0]        acc_vals [4];

  assign aux_vals[0] = bus.aux0;
  assign aux_vals[1] = bus.aux1;
  assign aux_vals[2] = bus.aux2;
  assign aux_vals[3] = bus.aux3;

  // A window of 2**WINDOW_LOG2 full-scale samples fits exactly in ACC_W bits.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_acc
      logic [ACC_W-1:0] acc_reg;

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
          acc_reg <= '0;
        end else if (acc_clear) begin
          acc_reg <= '0;
        end else if (acc_add) begin
          acc_reg <= acc_reg + {{WINDOW_LOG2{1'b0}}, aux_vals[gi]};
        end
      end

      assign acc_vals[gi] = acc_reg;
    end
  endgenerate

  assign busy = (state_reg == COMPARE) || (state_reg == PUBLISH);

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    k_next       = k_reg;
    best_next    = best_reg;
    second_next  = second_reg;
    idx_next     = idx_reg;
    net_next     = net_reg;
    amb_next     = amb_reg;
    valid_next   = 1'b0;
    dropped_next = dropped_reg;
    acc_clear    = 1'b0;
    acc_add      = 1'b0;

    if (busy && bus.sample_valid && (dropped_reg != 8'hFF)) begin
      dropped_next = dropped_reg + 8'd1;
    end

    case (state_reg)
      IDLE: begin
        if (bus.enable) begin
          state_next = ACCUM;
          acc_clear  = 1'b1;
          count_next = '0;
        end
      end

      ACCUM: begin
        // Dropping enable abandons the window even if a sample arrives alongside.
        if (!bus.enable) begin
          state_next = IDLE;
          acc_clear  = 1'b1;
          count_next = '0;
        end else if (bus.sample_valid) begin
          acc_add    = 1'b1;
          count_next = count_reg + COUNT_ONE;
          if (count_reg == COUNT_LAST) begin
            state_next = COMPARE;
            k_next     = 2'd0;
          end
        end
      end

      COMPARE: begin
        if (k_reg == 2'd0) begin
          best_next   = acc_vals[0];
          second_next = '0;
          idx_next    = 2'd0;
        end else if (acc_vals[k_reg] > best_reg) begin
          second_next = best_reg;
          best_next   = acc_vals[k_reg];
          idx_next    = k_reg;
        end else if (acc_vals[k_reg] > second_reg) begin
          second_next = acc_vals[k_reg];
        end
        k_next = k_reg + 2'd1;
        if (k_reg == 2'd3) begin
          state_next = PUBLISH;
        end
      end

      PUBLISH: begin
        if ((best_reg - second_reg) >= bus.margin) begin
          net_next = idx_reg;
          amb_next = 1'b0;
        end else begin
          amb_next = 1'b1;
        end
        valid_next = 1'b1;
        acc_clear  = 1'b1;
        count_next = '0;
        state_next = bus.enable ? ACCUM : IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      k_reg       <= 2'd0;
      best_reg    <= '0;
      second_reg  <= '0;
      idx_reg     <= 2'd0;
      net_reg     <= 2'd0;
      amb_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      dropped_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      k_reg       <= k_next;
      best_reg    <= best_next;
      second_reg  <= second_next;
      idx_reg     <= idx_next;
      net_reg     <= net_next;
      amb_reg     <= amb_next;
      valid_reg   <= valid_next;
      dropped_reg <= dropped_next;
    end
  end

  assign bus.network_output   = net_reg;
  assign bus.result_valid     = valid_reg;
  assign bus.result_ambiguous = amb_reg;
  assign bus.busy             = busy;
  assign bus.dropped_count    = dropped_reg;
endmodule
